// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - instruction fetch unit with a 2-entry prefetch FIFO and branch drain
// Ports:
//   clk, reset_n          : clock, synchronous active-low reset
//   mem_req, mem_addr     : word-aligned read request, held stable until mem_ready
//   mem_ready, mem_rdata  : same-cycle accept/data from instruction memory
//   instruction, pc_out   : head word and its byte address (zero when instr_valid=0)
//   instr_valid           : head holds an unconsumed word
//   pc_inc                : consume head word
//   branch_en/target      : flush FIFO and redirect the fetch stream
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic [31:0] pc_out,
    input  logic        pc_inc,
    input  logic        branch_en,
    input  logic [31:0] branch_target
);

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] drain_addr_q, drain_addr_d;
    logic [31:0] fifo_pc_q [2];
    logic [31:0] fifo_pc_d [2];
    logic [31:0] fifo_word_q [2];
    logic [31:0] fifo_word_d [2];
    logic        head_q, head_d;
    logic [1:0]  count_q, count_d;

    logic        push;
    logic        pop;
    logic        tail;

    always_comb begin
        // Gated by reset_n so no request is ever visible while reset is held.
        mem_req     = reset_n && ((state_q == ST_DRAIN) || !count_q[1]);
        mem_addr    = 32'h0;
        if (mem_req) begin
            // A drained request keeps its original address even though fetch_pc
            // already points at the branch target.
            mem_addr = (state_q == ST_DRAIN) ? drain_addr_q : fetch_pc_q;
        end
        instr_valid = (count_q != 2'd0);
        instruction = instr_valid ? fifo_word_q[head_q] : 32'h0;
        pc_out      = instr_valid ? fifo_pc_q[head_q]   : 32'h0;
    end

    always_comb begin
        push         = mem_req && mem_ready && (state_q == ST_FETCH) && !branch_en;
        pop          = instr_valid && pc_inc && !branch_en;
        tail         = head_q ^ count_q[0];
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        drain_addr_d = drain_addr_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_word_d  = fifo_word_q;
        head_d       = head_q;
        count_d      = count_q;

        // The outstanding request must complete before anything new is issued.
        if (state_q == ST_DRAIN) begin
            if (mem_ready) begin
                state_d = ST_FETCH;
            end
        end else if (branch_en && mem_req && !mem_ready) begin
            state_d      = ST_DRAIN;
            drain_addr_d = fetch_pc_q;
        end

        if (branch_en) begin
            fetch_pc_d = branch_target & 32'hFFFF_FFFC;
            head_d     = 1'b0;
            count_d    = 2'd0;
        end else begin
            if (push) begin
                fifo_pc_d[tail]   = fetch_pc_q;
                fifo_word_d[tail] = mem_rdata;
                fetch_pc_d        = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_FETCH;
            fetch_pc_q     <= RESET_PC & 32'hFFFF_FFFC;
            drain_addr_q   <= 32'h0;
            fifo_pc_q[0]   <= 32'h0;
            fifo_pc_q[1]   <= 32'h0;
            fifo_word_q[0] <= 32'h0;
            fifo_word_q[1] <= 32'h0;
            head_q         <= 1'b0;
            count_q        <= 2'd0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            drain_addr_q <= drain_addr_d;
            fifo_pc_q    <= fifo_pc_d;
            fifo_word_q  <= fifo_word_d;
            head_q       <= head_d;
            count_q      <= count_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch
module tb_instruction_fetch;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic [31:0] pc_out;
    logic        pc_inc = 1'b0;
    logic        branch_en = 1'b0;
    logic [31:0] branch_target = 32'h0;

    logic        rst2_n = 1'b0;
    logic        req2;
    logic [31:0] addr2;
    logic        ready2 = 1'b1;
    logic [31:0] rdata2;
    logic [31:0] instr2;
    logic        valid2;
    logic [31:0] pc2;
    logic        pcinc2 = 1'b0;
    logic        br2 = 1'b0;
    logic [31:0] bt2 = 32'h0;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    assign mem_rdata = mem_addr ^ KEY;
    assign rdata2    = addr2 ^ KEY;

    instruction_fetch u_dut (
        .clk(clk), .reset_n(reset_n), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .instruction(instruction),
        .instr_valid(instr_valid), .pc_out(pc_out), .pc_inc(pc_inc),
        .branch_en(branch_en), .branch_target(branch_target)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .reset_n(rst2_n), .mem_req(req2), .mem_addr(addr2),
        .mem_ready(ready2), .mem_rdata(rdata2), .instruction(instr2),
        .instr_valid(valid2), .pc_out(pc2), .pc_inc(pcinc2),
        .branch_en(br2), .branch_target(bt2)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] expq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every accepted consume is compared against the next expected pc.
    always @(negedge clk) begin
        if (reset_n && instr_valid && pc_inc && !branch_en) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_consume: got pc %h expected none", pc_out);
            end else begin
                logic [31:0] e;
                e = expq.pop_front();
                chk("consume_pc", pc_out, e);
                chk("consume_word", instruction, e ^ KEY);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        cyc();
        cyc();
        @(negedge clk);
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instruction, 32'h0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst2_req", {31'b0, req2}, 32'd0);

        // Fill with pc_inc=0
        cyc(); reset_n = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        chk("fill_req0", {31'b0, mem_req}, 32'd1);
        chk("fill_addr0", mem_addr, 32'h0);
        chk("fill_valid0", {31'b0, instr_valid}, 32'd0);
        cyc();
        @(negedge clk);
        chk("fill_addr1", mem_addr, 32'h4);
        chk("fill_valid1", {31'b0, instr_valid}, 32'd1);
        chk("fill_pc1", pc_out, 32'h0);
        cyc();
        @(negedge clk);
        chk("full_req", {31'b0, mem_req}, 32'd0);
        chk("full_pc", pc_out, 32'h0);
        chk("full_instr", instruction, 32'hA5A5_0000);

        // Streaming: consume six words, one per cycle
        for (int k = 0; k < 6; k++) expq.push_back(32'(k * 4));
        pc_inc = 1'b1;
        for (int i = 0; i < 5; i++) cyc();
        // Backpressure: request at 0x1C stalls for three cycles
        cyc(); pc_inc = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk("stream_drained", 32'(expq.size()), 32'd0);
        chk("stall_addr0", mem_addr, 32'h1C);
        for (int i = 0; i < 2; i++) begin
            cyc();
            @(negedge clk);
            chk("stall_req", {31'b0, mem_req}, 32'd1);
            chk("stall_addr", mem_addr, 32'h1C);
        end
        cyc(); mem_ready = 1'b1;
        cyc(); mem_ready = 1'b0;
        @(negedge clk);
        chk("stall_pushed_full", {31'b0, mem_req}, 32'd0);
        expq.push_back(32'h18);
        expq.push_back(32'h1C);
        pc_inc = 1'b1;
        cyc();
        cyc(); pc_inc = 1'b0;
        @(negedge clk);
        chk("pre_branch_addr", mem_addr, 32'h20);
        chk("pre_branch_empty", {31'b0, instr_valid}, 32'd0);

        // Branch during stalled request
        branch_en = 1'b1; branch_target = 32'h40;
        cyc(); branch_en = 1'b0;
        @(negedge clk);
        chk("drain_addr0", mem_addr, 32'h20);
        chk("drain_valid0", {31'b0, instr_valid}, 32'd0);
        cyc(); mem_ready = 1'b1;
        @(negedge clk);
        chk("drain_addr1", mem_addr, 32'h20);
        cyc();
        @(negedge clk);
        chk("redirect_addr", mem_addr, 32'h40);
        chk("redirect_valid", {31'b0, instr_valid}, 32'd0);
        cyc();
        @(negedge clk);
        chk("redirect_next", mem_addr, 32'h44);
        chk("redirect_pc", pc_out, 32'h40);
        chk("redirect_word", instruction, 32'hA5A5_0040);
        cyc();
        @(negedge clk);
        chk("full2_req", {31'b0, mem_req}, 32'd0);

        // Branch with idle memory, FIFO full; same-cycle pc_inc is discarded
        branch_en = 1'b1; branch_target = 32'h103; pc_inc = 1'b1;
        cyc(); pc_inc = 1'b0; branch_target = 32'h200; mem_ready = 1'b0;
        @(negedge clk);
        chk("flush_valid", {31'b0, instr_valid}, 32'd0);
        chk("flush_instr", instruction, 32'h0);
        chk("flush_pc", pc_out, 32'h0);
        chk("flush_addr", mem_addr, 32'h100);

        // Branch into DRAIN, then branch again while draining
        cyc(); branch_target = 32'h300;
        @(negedge clk);
        chk("redrain_addr", mem_addr, 32'h100);
        cyc(); branch_en = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        chk("redrain_hold", mem_addr, 32'h100);
        cyc();
        @(negedge clk);
        chk("newest_target", mem_addr, 32'h300);
        chk("scoreboard_empty", 32'(expq.size()), 32'd0);

        // Wrap instance
        cyc(); rst2_n = 1'b1; ready2 = 1'b1;
        @(negedge clk);
        chk("wrap_addr0", addr2, 32'hFFFF_FFFC);
        chk("wrap_req0", {31'b0, req2}, 32'd1);
        cyc(); ready2 = 1'b0;
        @(negedge clk);
        chk("wrap_addr1", addr2, 32'h0);
        chk("wrap_pc", pc2, 32'hFFFF_FFFC);
        chk("wrap_word", instr2, 32'h5A5A_FFFC);
        cyc();
        @(negedge clk);
        chk("wrap_stall", addr2, 32'h0);
        cyc(); rst2_n = 1'b0;
        cyc();
        @(negedge clk);
        chk("midrst_req", {31'b0, req2}, 32'd0);
        chk("midrst_addr", addr2, 32'h0);
        chk("midrst_valid", {31'b0, valid2}, 32'd0);
        chk("midrst_instr", instr2, 32'h0);
        chk("midrst_pc", pc2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: byte address of the first fetch after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 mem_req  output  1  instruction-memory read request.
REQ-005 mem_addr  output  32  byte address of requested word; bits [1:0] always 0.
REQ-006 mem_ready  input  1  memory accepts request and returns mem_rdata in the same cycle.
REQ-007 mem_rdata  input  32  instruction word; valid only when mem_req && mem_ready.
REQ-008 instruction  output  32  head instruction presented to controlpath.
REQ-009 instr_valid  output  1  instruction holds a valid, unconsumed word.
REQ-010 pc_out  output  32  byte address of the word on instruction.
REQ-011 pc_inc  input  1  controlpath consumes head word; same signal the controlpath drives.
REQ-012 branch_en  input  1  redirect fetch stream.
REQ-013 branch_target  input  32  redirect address; bits [1:0] forced to 0 internally.

Function
REQ-014 Block SHALL hold fetch_pc (32 b), a 2-entry FIFO of {pc, word}, and FSM states FETCH, DRAIN.
REQ-015 Handshake: once mem_req=1, mem_req and mem_addr SHALL stay stable until the cycle mem_ready=1.
REQ-016 In FETCH, a new request SHALL start only when FIFO count < 2; mem_addr = fetch_pc.
REQ-017 On mem_req && mem_ready in FETCH: {fetch_pc, mem_rdata} pushed; fetch_pc += 4 (mod 2^32, wraps FFFF_FFFC -> 0000_0000).
REQ-018 Pushed word SHALL appear on instruction with instr_valid=1 the next cycle (1-cycle latency), no combinational mem_rdata->instruction path.
REQ-019 pc_inc with instr_valid=1 SHALL pop head at the edge; pc_inc with instr_valid=0 SHALL be ignored.
REQ-020 Simultaneous push and pop SHALL leave count unchanged and preserve order; push into count 2 SHALL never occur.
REQ-021 instruction/pc_out SHALL be 0 when instr_valid=0.
REQ-022 branch_en=1 SHALL, at that edge: flush FIFO (instr_valid=0 next cycle), set fetch_pc = {branch_target[31:2],2'b00}, discard any same-cycle pc_inc and response.
REQ-023 branch_en while a request is pending and mem_ready=0 SHALL enter DRAIN: request held unchanged until mem_ready, its data discarded, then FETCH resumes at the new fetch_pc.
REQ-024 branch_en in DRAIN SHALL update fetch_pc to the newest target and remain in DRAIN.
REQ-025 No request SHALL start in DRAIN; first target request starts the cycle after DRAIN exits.
REQ-026 branch_en has priority over pc_inc and push in the same cycle.

Reset
REQ-027 While reset_n=0 at an edge: fetch_pc=RESET_PC, FIFO empty, state FETCH, mem_req=0, mem_addr=0, instr_valid=0, instruction=0, pc_out=0.
REQ-028 Reset SHALL override any pending request; handshake rule REQ-015 does not apply across reset.
REQ-029 First mem_req=1 SHALL occur in the first cycle after reset_n returns high.

Verification
REQ-030 Reset release, mem_ready tied 1, pc_inc=0 -> requests at 0x0, 0x4, then mem_req=0; instr_valid=1, pc_out=0x0, count 2.
REQ-031 Streaming: mem_ready=1, pc_inc=1 each cycle, rdata=addr^0xA5A5_0000 -> instruction sequence in address order, one per cycle, no gaps after fill.
REQ-032 Backpressure: mem_ready=0 for 3 cycles with mem_req=1 at 0x8 -> mem_addr held 0x8 all 3 cycles; word pushed on the ready cycle.
REQ-033 Branch with idle memory: FIFO full, branch_en=1, target 0x103 -> next cycle instr_valid=0; next request address 0x100.
REQ-034 Branch during stalled request at 0x10, target 0x40, mem_ready=1 two cycles later -> 0x10 data discarded, next request 0x40, first delivered pc_out=0x40.
REQ-035 Wrap: RESET_PC=0xFFFF_FFFC -> requests 0xFFFF_FFFC then 0x0000_0000; reset_n=0 mid-stall -> mem_req=0 next cycle, outputs per REQ-027.
